// File: rtl/fifo_stream_pkg.sv
// rtl/fifo_stream_pkg.sv - shared constants and types for the FIFO read-side stream stage
package fifo_stream_pkg;

  localparam int BUF_DEPTH          = 2;
  localparam int FIFO_WIDTH_DEFAULT = 16;

  typedef logic [1:0] occ_t;

endpackage

// File: rtl/stream_buf2.sv
// rtl/stream_buf2.sv - two-entry in-order holding buffer with write, pop, head and occupancy
module stream_buf2
  import fifo_stream_pkg::*;
#(
  parameter int WIDTH = FIFO_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output occ_t             occ
);

  logic [WIDTH-1:0] ent0_q, ent0_d;
  logic [WIDTH-1:0] ent1_q, ent1_d;
  occ_t             occ_q, occ_d;
  occ_t             occ_after_pop;

  // Apply the pop first so a simultaneous write lands behind whatever remains.
  always_comb begin
    ent0_d        = ent0_q;
    ent1_d        = ent1_q;
    occ_after_pop = occ_q;
    if (pop && (occ_q != '0)) begin
      ent0_d        = ent1_q;
      occ_after_pop = occ_q - 2'd1;
    end
    occ_d = occ_after_pop;
    if (wr && (occ_after_pop < occ_t'(BUF_DEPTH))) begin
      if (occ_after_pop == '0) begin
        ent0_d = wdata;
      end else begin
        ent1_d = wdata;
      end
      occ_d = occ_after_pop + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ent0_q <= '0;
      ent1_q <= '0;
      occ_q  <= '0;
    end else begin
      ent0_q <= ent0_d;
      ent1_q <= ent1_d;
      occ_q  <= occ_d;
    end
  end

  assign head = ent0_q;
  assign occ  = occ_q;

endmodule

// File: rtl/fifo_rd_stream.sv
// rtl/fifo_rd_stream.sv - drains a synchronous FIFO into a valid/ready stream with credit-gated reads
module fifo_rd_stream
  import fifo_stream_pkg::*;
#(
  parameter int FIFO_WIDTH = FIFO_WIDTH_DEFAULT,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  fifo_empty,
  input  logic                  fifo_underflow,
  input  logic [FIFO_WIDTH-1:0] fifo_data_out,
  output logic                  fifo_rd_en,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [FIFO_WIDTH-1:0] m_data,
  output logic [CNT_WIDTH-1:0]  words_out,
  output logic                  rd_err
);

  occ_t                 occ;
  occ_t                 used;
  occ_t                 credit;
  logic                 pop;
  logic                 inflight_q, inflight_d;
  logic                 rd_err_q, rd_err_d;
  logic [CNT_WIDTH-1:0] words_q, words_d;

  assign m_valid = (occ != '0);
  assign pop     = m_valid && m_ready;

  // A word popped this cycle frees its slot in time for a read issued now.
  always_comb begin
    used       = occ + {1'b0, inflight_q};
    credit     = used - {1'b0, pop};
    fifo_rd_en = !rst && enable && !fifo_empty && (credit < occ_t'(BUF_DEPTH));
    inflight_d = fifo_rd_en;
    words_d    = words_q + {{(CNT_WIDTH-1){1'b0}}, pop};
    rd_err_d   = rd_err_q | fifo_underflow;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      inflight_q <= 1'b0;
      words_q    <= '0;
      rd_err_q   <= 1'b0;
    end else begin
      inflight_q <= inflight_d;
      words_q    <= words_d;
      rd_err_q   <= rd_err_d;
    end
  end

  stream_buf2 #(
    .WIDTH (FIFO_WIDTH)
  ) u_buf (
    .clk   (clk),
    .rst   (rst),
    .wr    (inflight_q),
    .wdata (fifo_data_out),
    .pop   (pop),
    .head  (m_data),
    .occ   (occ)
  );

  assign words_out = words_q;
  assign rd_err    = rd_err_q;

endmodule

// File: tb/tb_fifo_rd_stream.sv
// tb/tb_fifo_rd_stream.sv - randomized and directed bench for fifo_rd_stream against a word-level model
module tb_fifo_rd_stream;

  localparam int W  = 16;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          enable;
  logic          fifo_empty;
  logic          fifo_underflow;
  logic [W-1:0]  fifo_data_out = '0;
  logic          fifo_rd_en;
  logic          m_valid;
  logic          m_ready;
  logic [W-1:0]  m_data;
  logic [CW-1:0] words_out;
  logic          rd_err;

  always #5 clk = ~clk;

  fifo_rd_stream #(
    .FIFO_WIDTH (W),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .enable         (enable),
    .fifo_empty     (fifo_empty),
    .fifo_underflow (fifo_underflow),
    .fifo_data_out  (fifo_data_out),
    .fifo_rd_en     (fifo_rd_en),
    .m_valid        (m_valid),
    .m_ready        (m_ready),
    .m_data         (m_data),
    .words_out      (words_out),
    .rd_err         (rd_err)
  );

  // Upstream FIFO: unbounded array, one-cycle read latency.
  logic [W-1:0] mem [0:4095];
  int           wr_ptr = 0;
  int           rd_ptr = 0;

  assign fifo_empty = (rd_ptr == wr_ptr);

  always @(posedge clk) begin
    if (fifo_rd_en) begin
      fifo_data_out <= mem[rd_ptr % 4096];
      rd_ptr        <= rd_ptr + 1;
    end
  end

  // Model: words read but not yet delivered, in order; the last is still in flight when inflight_m.
  logic [W-1:0] exp_q [$];
  bit           inflight_m = 1'b0;
  int           pops_m     = 0;
  bit           err_m      = 1'b0;
  int           mptr       = 0;

  int  n_checks = 0;
  int  n_fail   = 0;
  bit  rd_seen;
  bit  valid_seen;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic push(input logic [W-1:0] word);
    mem[wr_ptr % 4096] = word;
    wr_ptr++;
  endtask

  // Called at a negedge with inputs already driven; returns at the following negedge.
  task automatic step();
    int held;
    bit exp_valid, exp_pop, exp_rd;
    #1;
    held      = exp_q.size();
    exp_valid = (held - int'(inflight_m)) > 0;
    exp_pop   = exp_valid && m_ready;
    exp_rd    = !rst && enable && !fifo_empty && ((held - int'(exp_pop)) < 2);
    check("rd_en", 32'(fifo_rd_en), 32'(exp_rd));
    check("m_valid", 32'(m_valid), 32'(exp_valid));
    if (exp_valid) check("m_data", 32'(m_data), 32'(exp_q[0]));
    check("words_out", 32'(words_out), 32'(pops_m % (1 << CW)));
    check("rd_err", 32'(rd_err), 32'(err_m));
    rd_seen    = fifo_rd_en;
    valid_seen = m_valid;
    @(posedge clk);
    if (rst) begin
      exp_q.delete();
      inflight_m = 1'b0;
      pops_m     = 0;
      err_m      = 1'b0;
    end else begin
      if (exp_pop) begin
        void'(exp_q.pop_front());
        pops_m++;
      end
      if (exp_rd) begin
        exp_q.push_back(mem[mptr % 4096]);
        mptr++;
      end
      inflight_m = exp_rd;
      if (fifo_underflow) err_m = 1'b1;
    end
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  int cnt_a;
  int cnt_b;

  initial begin
    rst            = 1'b1;
    enable         = 1'b1;
    m_ready        = 1'b1;
    fifo_underflow = 1'b0;
    for (int i = 0; i < 5; i++) push(W'(16'hA001 + i));
    @(negedge clk);

    // Reset with a non-empty FIFO, then first read right after release.
    step();
    step();
    check("rst_m_data", 32'(m_data), 32'h0);
    check("rst_words", 32'(words_out), 32'h0);
    rst = 1'b0;
    step();
    check("first_rd_after_rst", 32'(rd_seen), 32'h1);
    run(8);

    // Streaming 1..8 with the consumer always ready.
    do_reset();
    for (int i = 1; i <= 8; i++) push(W'(i));
    cnt_a = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      cnt_a += int'(rd_seen);
    end
    check("stream_rd_cycles", 32'(cnt_a), 32'd8);
    run(3);
    check("stream_words", 32'(words_out), 32'd8);

    // Backpressure: only two reads while stalled, head held.
    do_reset();
    for (int i = 0; i < 4; i++) push(W'(16'hB000 + i));
    m_ready = 1'b0;
    cnt_a = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      cnt_a += int'(rd_seen);
    end
    check("stall_reads", 32'(cnt_a), 32'd2);
    check("stall_head", 32'(m_data), 32'hB000);
    m_ready = 1'b1;
    run(6);
    check("stall_words", 32'(words_out), 32'd4);

    // Single word then empty.
    do_reset();
    push(16'hC0DE);
    cnt_a = 0;
    cnt_b = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      cnt_a += int'(rd_seen);
      cnt_b += int'(valid_seen);
    end
    check("empty_rd_pulses", 32'(cnt_a), 32'd1);
    check("empty_valid_cycles", 32'(cnt_b), 32'd1);

    // Reset while a word is held and another is in flight.
    do_reset();
    for (int i = 0; i < 6; i++) push(W'(16'hD000 + i));
    run(2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    check("midrst_valid", 32'(valid_seen), 32'h0);
    check("midrst_words", 32'(words_out), 32'h0);
    run(10);

    // Sticky underflow error and counter wrap.
    do_reset();
    fifo_underflow = 1'b1;
    step();
    fifo_underflow = 1'b0;
    run(3);
    check("err_sticky", 32'(rd_err), 32'h1);
    for (int i = 0; i < 17; i++) push(W'(16'hE000 + i));
    run(22);
    check("wrap_words", 32'(words_out), 32'h1);
    do_reset();
    check("err_cleared", 32'(rd_err), 32'h0);

    // Random traffic with random enable and backpressure.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 99) < 45) push(W'($urandom));
      enable  = ($urandom_range(0, 99) < 80);
      m_ready = ($urandom_range(0, 99) < 60);
      step();
    end
    enable  = 1'b1;
    m_ready = 1'b1;
    run(400);
    check("rand_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
